branch_outcome_queue: RTL and testbench

// In-order tracker between the fetch/execute pipeline and the 2-bit global-history

---
 rtl/branch_outcome_queue.sv | 129 ++++++++++++
 tb/tb_branch_outcome_queue.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/branch_outcome_queue.sv
// Purpose: in-order tracker between fetch/execute and the global-history predictor.
// Latency: a prediction is visible to fetch one cycle after its request; predictor updates are combinational with resolve.
// Backpressure: br_ready drops when the queue is full, in reset, or on a mispredicting resolve.
//
// Ports:
//   clk, reset                      - single clock, synchronous active-high reset
//   br_fetch / br_ready             - fetch branch request and acceptance
//   pred_request / pred_bit         - predictor request; its answer arrives the following cycle
//   fetch_pred_valid / fetch_pred   - prediction returned to fetch
//   resolve_valid / resolve_taken   - execute resolves the oldest outstanding branch
//   upd_result / upd_taken          - predictor training update
//   mispredict, occupancy, mp_count - status: one-cycle mispredict pulse, fill level, saturating count
module branch_outcome_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             br_fetch,
    output logic             br_ready,
    output logic             pred_request,
    input  logic             pred_bit,
    output logic             fetch_pred_valid,
    output logic             fetch_pred,
    input  logic             resolve_valid,
    input  logic             resolve_taken,
    output logic             upd_result,
    output logic             upd_taken,
    output logic             mispredict,
    output logic [PTR_W:0]   occupancy,
    output logic [CNT_W-1:0] mp_count
);

    logic [DEPTH-1:0] pred_mem_q, pred_mem_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   occ_q, occ_d;
    logic             pending_q, pending_d;
    logic             mispredict_q, mispredict_d;
    logic [CNT_W-1:0] mp_count_q, mp_count_d;

    logic live_res;
    logic head_pred;
    logic mp_now;

    always_comb begin
        // Resolves are ignored with an empty queue, and suppressed during reset
        // so the predictor never trains on discarded state.
        live_res = resolve_valid & (occ_q != '0) & ~reset;

        // The only entry can still be waiting for its prediction; use the
        // predictor output directly in that case since the store lands at this edge.
        if ((occ_q == (PTR_W+1)'(1)) && pending_q) begin
            head_pred = pred_bit;
        end else begin
            head_pred = pred_mem_q[head_q];
        end

        mp_now       = live_res & (resolve_taken != head_pred);
        br_ready     = ~reset & (occ_q < (PTR_W+1)'(DEPTH)) & ~mp_now;
        pred_request = br_fetch & br_ready;

        fetch_pred_valid = pending_q;
        fetch_pred       = pred_bit;
        upd_result       = live_res;
        upd_taken        = resolve_taken;
        mispredict       = mispredict_q;
        occupancy        = occ_q;
        mp_count         = mp_count_q;
    end

    always_comb begin
        pred_mem_d   = pred_mem_q;
        head_d       = head_q;
        tail_d       = tail_q;
        occ_d        = occ_q;
        pending_d    = 1'b0;
        mispredict_d = mp_now;
        mp_count_d   = mp_count_q;

        // Capture last cycle's prediction into the most recently allocated slot.
        if (pending_q) begin
            pred_mem_d[tail_q - PTR_W'(1)] = pred_bit;
        end

        if (mp_now) begin
            // Everything younger than the resolved branch is wrong-path: drop all.
            // Allocation is blocked this cycle, so tail_q is the final tail.
            head_d    = tail_q;
            occ_d     = '0;
            pending_d = 1'b0;
            if (!(&mp_count_q)) begin
                mp_count_d = mp_count_q + CNT_W'(1);
            end
        end else begin
            if (pred_request) begin
                pred_mem_d[tail_q] = 1'b0;
                tail_d             = tail_q + PTR_W'(1);
                pending_d          = 1'b1;
            end
            if (live_res) begin
                head_d = head_q + PTR_W'(1);
            end
            occ_d = occ_q + (PTR_W+1)'(pred_request) - (PTR_W+1)'(live_res);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pred_mem_q   <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            occ_q        <= '0;
            pending_q    <= 1'b0;
            mispredict_q <= 1'b0;
            mp_count_q   <= '0;
        end else begin
            pred_mem_q   <= pred_mem_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            occ_q        <= occ_d;
            pending_q    <= pending_d;
            mispredict_q <= mispredict_d;
            mp_count_q   <= mp_count_d;
        end
    end

endmodule

// File: tb/tb_branch_outcome_queue.sv
module tb_branch_outcome_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        br_fetch;
    logic        br_ready;
    logic        pred_request;
    logic        pred_bit;
    logic        fetch_pred_valid;
    logic        fetch_pred;
    logic        resolve_valid;
    logic        resolve_taken;
    logic        upd_result;
    logic        upd_taken;
    logic        mispredict;
    logic [2:0]  occupancy;
    logic [15:0] mp_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_outcome_queue #(.DEPTH(4), .PTR_W(2), .CNT_W(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .br_fetch         (br_fetch),
        .br_ready         (br_ready),
        .pred_request     (pred_request),
        .pred_bit         (pred_bit),
        .fetch_pred_valid (fetch_pred_valid),
        .fetch_pred       (fetch_pred),
        .resolve_valid    (resolve_valid),
        .resolve_taken    (resolve_taken),
        .upd_result       (upd_result),
        .upd_taken        (upd_taken),
        .mispredict       (mispredict),
        .occupancy        (occupancy),
        .mp_count         (mp_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle: new inputs go in just after the rising edge,
    // outputs are sampled on the following falling edge.
    task automatic step(input logic f, input logic pb, input logic rv, input logic rt);
        @(posedge clk);
        #1;
        br_fetch      = f;
        pred_bit      = pb;
        resolve_valid = rv;
        resolve_taken = rt;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; br_fetch = 1'b0; pred_bit = 1'b0;
        resolve_valid = 1'b0; resolve_taken = 1'b0;

        // 1: reset
        step(1, 0, 1, 1);
        chk("rst_br_ready", br_ready, 0);
        chk("rst_pred_req", pred_request, 0);
        chk("rst_upd_result", upd_result, 0);
        step(0, 0, 0, 0);
        @(posedge clk); #1; reset = 1'b0; @(negedge clk);
        chk("rst_occ", occupancy, 0);
        chk("rst_br_ready_after", br_ready, 1);
        chk("rst_mispredict", mispredict, 0);
        chk("rst_mp_count", mp_count, 0);
        chk("rst_fpv", fetch_pred_valid, 0);

        // 2: single branch, predicted and resolved taken
        step(1, 0, 0, 0);
        chk("t2_pred_req", pred_request, 1);
        step(0, 1, 0, 0);
        chk("t2_fpv", fetch_pred_valid, 1);
        chk("t2_fpred", fetch_pred, 1);
        chk("t2_occ", occupancy, 1);
        step(0, 0, 1, 1);
        chk("t2_fpv_clr", fetch_pred_valid, 0);
        chk("t2_upd_result", upd_result, 1);
        chk("t2_upd_taken", upd_taken, 1);
        chk("t2_no_mp_ready", br_ready, 1);
        step(0, 0, 0, 0);
        chk("t2_occ_after", occupancy, 0);
        chk("t2_mispredict", mispredict, 0);

        // 3: fill to capacity with predictions 1,1,1,0
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("t3_occ_3_ready", br_ready, 1);
        step(1, 0, 0, 0);
        chk("t3_occ_full", occupancy, 4);
        chk("t3_br_ready", br_ready, 0);
        chk("t3_pred_req", pred_request, 0);
        // full + pop: still no allocation
        step(1, 0, 1, 1);
        chk("t3_full_pop_noalloc", pred_request, 0);
        chk("t3_full_pop_upd", upd_result, 1);
        step(0, 0, 1, 1);
        chk("t3_occ3", occupancy, 3);
        step(0, 0, 1, 1);
        step(0, 0, 1, 0);
        chk("t3_last_upd", upd_result, 1);
        step(0, 0, 0, 0);
        chk("t3_drained", occupancy, 0);
        chk("t3_no_mp", mp_count, 0);

        // 4: three outstanding, oldest predicted not-taken, resolves taken
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("t4_occ3", occupancy, 3);
        step(1, 0, 1, 1);
        chk("t4_upd_result", upd_result, 1);
        chk("t4_mp_blocks_ready", br_ready, 0);
        chk("t4_mp_blocks_req", pred_request, 0);
        step(0, 0, 0, 0);
        chk("t4_mispredict", mispredict, 1);
        chk("t4_occ_flushed", occupancy, 0);
        chk("t4_mp_count", mp_count, 1);
        chk("t4_fpv", fetch_pred_valid, 0);
        step(0, 0, 0, 0);
        chk("t4_mispredict_pulse", mispredict, 0);

        // 5: alloc and correct resolve in the same cycle, then FIFO order
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(1, 0, 1, 1);
        chk("t5_req", pred_request, 1);
        chk("t5_upd", upd_result, 1);
        chk("t5_ready", br_ready, 1);
        step(0, 0, 0, 0);
        chk("t5_occ_held", occupancy, 1);
        chk("t5_fpv", fetch_pred_valid, 1);
        step(0, 0, 1, 0);
        chk("t5_ready_no_mp", br_ready, 1);
        step(0, 0, 0, 0);
        chk("t5_order_no_mp", mispredict, 0);
        chk("t5_occ0", occupancy, 0);
        chk("t5_mp_count", mp_count, 1);

        // 6: resolve uses the bypassed prediction, then empty resolve
        step(1, 0, 0, 0);
        step(0, 1, 1, 0);
        chk("t6_bypass_upd", upd_result, 1);
        chk("t6_bypass_mp", br_ready, 0);
        step(0, 0, 1, 1);
        chk("t6_mispredict", mispredict, 1);
        chk("t6_mp_count", mp_count, 2);
        chk("t6_empty_upd", upd_result, 0);
        chk("t6_empty_ready", br_ready, 1);
        step(0, 0, 0, 0);
        chk("t6_pulse_end", mispredict, 0);
        chk("t6_count_held", mp_count, 2);

        // Reset mid-operation discards entries and suppresses updates
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        @(posedge clk); #1;
        reset = 1'b1; br_fetch = 1'b1; resolve_valid = 1'b1; resolve_taken = 1'b0;
        @(negedge clk);
        chk("mr_upd_result", upd_result, 0);
        chk("mr_pred_req", pred_request, 0);
        step(0, 0, 0, 0);
        @(posedge clk); #1; reset = 1'b0; @(negedge clk);
        chk("mr_occ", occupancy, 0);
        chk("mr_fpv", fetch_pred_valid, 0);
        chk("mr_mp_count", mp_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
